pcileech_eth_rxbuf: RTL and testbench

//  Receive-side width converter for the UDP Ethernet path. Packs the 32-bit word stream leaving the

---
 rtl/pcileech_eth_rxbuf.sv | 197 +++++++++++++++++++
 tb/tb_pcileech_eth_rxbuf.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_eth_rxbuf.sv
// Receive-side 32->256 bit packer with a first-word-fall-through output FIFO.
// Optional idle-timeout flush of partial words is enabled by defining PCILEECH_ETH_RXBUF_FLUSH_EN.
module pcileech_eth_rxbuf #(
  parameter int          PARAM_FIFO_DEPTH   = 16,
  parameter logic [31:0] PARAM_PAD_WORD     = 32'h66665555,
  parameter int          PARAM_FLUSH_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  din,
  input  logic         din_valid,
  output logic [255:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overflow,
  output logic [15:0]  drop_count,
  output logic         led_state_rxdata
);

  localparam int AW = $clog2(PARAM_FIFO_DEPTH);
  localparam int TW = $clog2(PARAM_FLUSH_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(PARAM_FIFO_DEPTH);
  localparam logic [TW-1:0] FLUSH_AT  = TW'(PARAM_FLUSH_CYCLES);

`ifdef PCILEECH_ETH_RXBUF_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0][31:0]   slot_q, slot_d;
  logic [31:0]        hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [255:0]       dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_count_q, drop_count_d;

  logic [255:0]       mem_q [PARAM_FIFO_DEPTH];

  logic               push_req;
  logic               push_ok;
  logic               drop;
  logic               pop;
  logic               full;
  logic [255:0]       push_word;
  logic [2:0]         fill_n;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    timer_d       = timer_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;
    push_req      = 1'b0;
    push_word     = slot_q;
    fill_n        = 3'd0;

    pop  = dout_valid_q & dout_ready;
    full = (count_q == DEPTH_CNT);

    case (state_q)
      ST_EMPTY, ST_FILL: begin
        if (din_valid) begin
          slot_d[idx_q] = din;
          timer_d       = '0;
          if (idx_q == 3'd7) begin
            push_req  = 1'b1;
            push_word = {din, slot_q[6:0]};
            idx_d     = 3'd0;
            state_d   = ST_EMPTY;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_FILL;
          end
        end else if (FLUSH_EN && (state_q == ST_FILL)) begin
          timer_d = timer_q + 1'b1;
          if (timer_d == FLUSH_AT) begin
            timer_d = '0;
            state_d = ST_FLUSH;
            for (int i = 0; i < 8; i++) begin
              if (i >= int'(idx_q)) slot_d[i] = PARAM_PAD_WORD;
            end
          end
        end
      end
      ST_FLUSH: begin
        // The padded word waits here for room; a word arriving meanwhile is parked in hold_q.
        if (!full) begin
          push_req     = 1'b1;
          push_word    = slot_q;
          hold_valid_d = 1'b0;
          timer_d      = '0;
          if (hold_valid_q) begin
            slot_d[0] = hold_q;
            fill_n    = 3'd1;
          end
          if (din_valid) begin
            slot_d[fill_n] = din;
            fill_n         = fill_n + 3'd1;
          end
          idx_d   = fill_n;
          state_d = (fill_n != 3'd0) ? ST_FILL : ST_EMPTY;
        end else if (din_valid && !hold_valid_q) begin
          hold_d       = din;
          hold_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = 3'd0;
      end
    endcase

    push_ok = push_req & ~full;
    drop    = push_req & full;

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    // Head register: a push landing on an empty (after pop) queue bypasses memory.
    dout_valid_d = (count_d != '0);
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) dout_d = push_word;
      else                                   dout_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      idx_q        <= 3'd0;
      slot_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign dout             = dout_q;
  assign dout_valid       = dout_valid_q;
  assign overflow         = overflow_q;
  assign drop_count       = drop_count_q;
  assign led_state_rxdata = dout_valid_q;

endmodule

// File: tb/tb_pcileech_eth_rxbuf.sv
// Randomised self-checking bench for pcileech_eth_rxbuf against a queue-based packing model.
module tb_pcileech_eth_rxbuf;

  localparam int          DEPTH  = 16;
  localparam int          FLUSHC = 40;
  localparam logic [31:0] PAD    = 32'h66665555;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  din = '0;
  logic         din_valid = 1'b0;
  logic [255:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overflow;
  logic [15:0]  drop_count;
  logic         led_state_rxdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  pcileech_eth_rxbuf #(
    .PARAM_FIFO_DEPTH   (DEPTH),
    .PARAM_PAD_WORD     (PAD),
    .PARAM_FLUSH_CYCLES (FLUSHC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .din              (din),
    .din_valid        (din_valid),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .overflow         (overflow),
    .drop_count       (drop_count),
    .led_state_rxdata (led_state_rxdata)
  );

  always #5 clk = ~clk;

  // Reference model: eight-entry staging array feeding a bounded queue of packed words.
  logic [255:0] m_fifo [$];
  logic [31:0]  m_part [8];
  int           m_idx = 0;
  bit           m_ovf = 1'b0;
  int           m_drops = 0;
  bit           m_pop, m_full, m_have;
  logic [255:0] m_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_idx   = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_pop  = (m_fifo.size() != 0) && dout_ready;
      m_full = (m_fifo.size() == DEPTH);
      m_have = 1'b0;
      if (din_valid) begin
        m_part[m_idx] = din;
        if (m_idx == 7) begin
          for (int i = 0; i < 8; i++) m_word[i*32 +: 32] = m_part[i];
          m_have = 1'b1;
        end
        m_idx = (m_idx + 1) % 8;
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_have) begin
        if (m_full) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_fifo.push_back(m_word);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    din_valid  = v;
    din        = d;
    dout_ready = r;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      checkOutput("dout_valid", 256'(dout_valid), 256'(m_fifo.size() != 0));
      checkOutput("led", 256'(led_state_rxdata), 256'(m_fifo.size() != 0));
      checkOutput("overflow", 256'(overflow), 256'(m_ovf));
      checkOutput("drop_count", 256'(drop_count), 256'(m_drops));
      if (m_fifo.size() != 0) checkOutput("dout", dout, m_fifo[0]);
    end
  end

  logic [255:0] exp_w;
  int           pops;
  int           n;

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", dout, 256'd0);
    checkOutput("rst_valid", 256'(dout_valid), 256'd0);
    checkOutput("rst_ovf", 256'(overflow), 256'd0);
    checkOutput("rst_drops", 256'(drop_count), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: single packet");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) checkOutput("t1_not_early", 256'(dout_valid), 256'd0);
      applyStimulus(1'b1, 32'(i), 1'b1);
    end
    for (int i = 0; i < 8; i++) exp_w[i*32 +: 32] = 32'(i);
    checkOutput("t1_valid", 256'(dout_valid), 256'd1);
    checkOutput("t1_dout", dout, exp_w);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t1_popped", 256'(dout_valid), 256'd0);

    $display("[TB] test 2: overfill");
    for (int p = 0; p < DEPTH + 2; p++)
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, {16'(p), 16'(i)}, 1'b0);
    checkOutput("t2_ovf", 256'(overflow), 256'd1);
    checkOutput("t2_drops", 256'(drop_count), 256'd2);
    checkOutput("t2_model_size", 256'(m_fifo.size()), 256'(DEPTH));

    $display("[TB] test 3: drop with simultaneous pop");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'hBEEF0000 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'hBEEF0007, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("t3_drops", 256'(drop_count), 256'd3);
    pops = 0;
    for (int c = 0; c < 3 * DEPTH && dout_valid; c++) begin
      pops++;
      applyStimulus(1'b0, 32'd0, 1'b1);
    end
    checkOutput("t3_remaining", 256'(pops), 256'(DEPTH - 1));
    applyStimulus(1'b0, 32'd0, 1'b0);

    $display("[TB] test 4: partial word then idle");
`ifdef PCILEECH_ETH_RXBUF_FLUSH_EN
    chk_en = 1'b0;
    applyStimulus(1'b1, 32'hA, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0);
    n = 0;
    while (!dout_valid && n < FLUSHC + 50) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      n++;
    end
    exp_w = {PAD, PAD, PAD, PAD, PAD, 32'hC, 32'hB, 32'hA};
    checkOutput("t4_flush_seen", 256'(dout_valid), 256'd1);
    checkOutput("t4_flush_dout", dout, exp_w);
    applyStimulus(1'b0, 32'd0, 1'b1);
`else
    applyStimulus(1'b1, 32'hA, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0);
    repeat (FLUSHC + 20) applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("t4_no_flush", 256'(dout_valid), 256'd0);
`endif

    $display("[TB] test 5: reset mid-packet");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hDEAD0000 + 32'(i), 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) exp_w[i*32 +: 32] = 32'h100 + 32'(i);
    checkOutput("t5_valid", 256'(dout_valid), 256'd1);
    checkOutput("t5_dout", dout, exp_w);
    checkOutput("t5_ovf", 256'(overflow), 256'd0);
    checkOutput("t5_drops", 256'(drop_count), 256'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);

    $display("[TB] test 6: gapped random traffic");
    for (int w = 0; w < 1000; w++) begin
      applyStimulus(1'b1, $urandom, 1'($urandom_range(0, 1)));
      applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)));
      applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (m_fifo.size() != 0 && n < 4 * DEPTH) begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      n++;
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("t6_drained", 256'(dout_valid), 256'd0);
    checkOutput("t6_no_loss", 256'(drop_count), 256'd0);
    checkOutput("t6_model_drops", 256'(m_drops), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
